// File: rtl/fft_ctrl.sv
// fft_ctrl: radix-2 DIT FFT sequencer.
// Walks LOG2N stages of N/2 butterflies over an in-place sample RAM and issues
// read, twiddle and one-cycle-delayed write-back addresses. A one-cycle DRAIN
// bubble separates stages so the next stage's first read never overtakes the
// current stage's last write.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; addresses hold their last values
// S_RUN   | one butterfly read per clock, k = 0..N/2-1
// S_DRAIN | read bubble; last write of the stage lands here
// S_DONE  | one-cycle done pulse, then back to idle
module fft_ctrl #(
  parameter int LOG2N = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [LOG2N-2:0] K_LAST = '1;
  localparam logic [LOG2N-2:0] K_ONE  = (LOG2N-1)'(1);
  localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N-1);
  localparam logic [LOG2N-1:0] S_ONE  = LOG2N'(1);

  state_t           state_q, state_d;
  logic [LOG2N-2:0] k_q, k_d;
  logic [LOG2N-1:0] stage_q, stage_d;

  logic             rd_en_q, rd_en_d;
  logic [LOG2N-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [LOG2N-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [LOG2N-2:0] tw_addr_q, tw_addr_d;
  logic             wr_en_q, wr_en_d;
  logic [LOG2N-1:0] wr_addr_a_q, wr_addr_a_d;
  logic [LOG2N-1:0] wr_addr_b_q, wr_addr_b_d;

  logic [LOG2N-2:0] low_mask, j_n, k_hi;
  logic [LOG2N-1:0] half, addr_a;

  // Next-state and butterfly/stage counter update.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          k_d     = '0;
          stage_d = '0;
        end
      end
      S_RUN: begin
        if (k_q == K_LAST) state_d = S_DRAIN;
        else               k_d     = k_q + K_ONE;
      end
      S_DRAIN: begin
        if (stage_q == S_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
          stage_d = stage_q + S_ONE;
          k_d     = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read/twiddle address generation for the butterfly entering RUN next cycle;
  // j is the low s bits of k, the group index is shifted up one to skip the b half.
  always_comb begin
    low_mask    = ~(K_LAST << stage_d);
    j_n         = k_d & low_mask;
    k_hi        = k_d & ~low_mask;
    half        = S_ONE << stage_d;
    addr_a      = {k_hi, 1'b0} | {1'b0, j_n};
    rd_en_d     = 1'b0;
    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;
    tw_addr_d   = tw_addr_q;
    if (state_d == S_RUN) begin
      rd_en_d     = 1'b1;
      rd_addr_a_d = addr_a;
      rd_addr_b_d = addr_a | half;
      tw_addr_d   = j_n << (S_LAST - stage_d);
    end
  end

  // Write-back follows the read by one clock (sync RAM read + comb butterfly).
  always_comb begin
    wr_en_d     = rd_en_q;
    wr_addr_a_d = rd_en_q ? rd_addr_a_q : wr_addr_a_q;
    wr_addr_b_d = rd_en_q ? rd_addr_b_q : wr_addr_b_q;
  end

  // State, counters and registered outputs; reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      stage_q     <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_a_q <= '0;
      wr_addr_b_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      stage_q     <= stage_d;
      rd_en_q     <= rd_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      tw_addr_q   <= tw_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_a_q <= wr_addr_a_d;
      wr_addr_b_q <= wr_addr_b_d;
    end
  end

  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign stage     = stage_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_addr_a_q;
  assign rd_addr_b = rd_addr_b_q;
  assign tw_addr   = tw_addr_q;
  assign wr_en     = wr_en_q;
  assign wr_addr_a = wr_addr_a_q;
  assign wr_addr_b = wr_addr_b_q;

endmodule
